seg_scan_drv: RTL and testbench

//  Consumer end of the scan-tick interface driven by cnt_100M: multiplexes N BCD digits

---
 rtl/seg_scan_if.sv | 13 +
 rtl/seg_scan_drv.sv | 143 ++++++++++++++
 tb/tb_seg_scan_drv.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Display-data handshake between a producer and seg_scan_drv.
// The producer offers a full digit set; the driver latches it into its pending buffer.
interface seg_scan_if #(
  parameter int N_DIGITS = 8
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [4*N_DIGITS-1:0]   in_digits;
  logic [N_DIGITS-1:0]     in_dp;

  modport master (output in_valid, output in_digits, output in_dp, input in_ready);
  modport slave  (input in_valid, input in_digits, input in_dp, output in_ready);
endinterface

// File: rtl/seg_scan_drv.sv
// Multiplexed 7-segment scan driver with ghost blanking and frame-synchronous double buffering.
//  state | meaning
//  BLANK | all segments/anodes off for BLANK_CLKS clocks between digits
//  SHOW  | digit idx driven until the next scan tick
module seg_scan_drv #(
  parameter int N_DIGITS   = 8,
  parameter int BLANK_CLKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                lz_en,
  seg_scan_if.slave           bus,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                frame_done
);
  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = (BLANK_CLKS > 1) ? $clog2(BLANK_CLKS) : 1;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic [4*N_DIGITS-1:0] active, active_n, pend_digits, pend_digits_n;
  logic [N_DIGITS-1:0]   active_dp, active_dp_n, pend_dp, pend_dp_n;
  logic                  pend, pend_n;
  logic                  boundary, xfer, all_zero;
  logic [N_DIGITS-1:0]   zero_above;
  logic [3:0]            digit;
  logic [N_DIGITS-1:0]   an_n;
  logic [6:0]            seg_n;
  logic                  dp_n;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 7'h40;
      4'd1: decode = 7'h79;
      4'd2: decode = 7'h24;
      4'd3: decode = 7'h30;
      4'd4: decode = 7'h19;
      4'd5: decode = 7'h12;
      4'd6: decode = 7'h02;
      4'd7: decode = 7'h78;
      4'd8: decode = 7'h00;
      4'd9: decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    idx_n         = idx;
    active_n      = active;
    active_dp_n   = active_dp;
    pend_n        = pend;
    pend_digits_n = pend_digits;
    pend_dp_n     = pend_dp;
    boundary      = 1'b0;
    xfer          = bus.in_valid & bus.in_ready;

    case (state)
      BLANK: begin
        if (cnt == '0) state_n = SHOW;
        else           cnt_n   = cnt - CW'(1);
      end
      SHOW: begin
        if (tick) begin
          state_n  = BLANK;
          cnt_n    = CW'(BLANK_CLKS - 1);
          boundary = (idx == IW'(N_DIGITS - 1));
          idx_n    = boundary ? '0 : idx + IW'(1);
        end
      end
      default: state_n = BLANK;
    endcase

    if (boundary && pend) begin
      active_n    = pend_digits;
      active_dp_n = pend_dp;
    end
    // A transfer can only coincide with a boundary when nothing is pending, so it wins.
    if (xfer) begin
      pend_n        = 1'b1;
      pend_digits_n = bus.in_digits;
      pend_dp_n     = bus.in_dp;
    end else if (boundary) begin
      pend_n = 1'b0;
    end

    all_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      all_zero      = all_zero & (active_n[4*i +: 4] == 4'd0);
      zero_above[i] = all_zero;
    end

    digit = active_n[{idx_n, 2'b00} +: 4];
    an_n  = '1;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    // Outputs are registered from next-state values so they line up with the state register.
    if (state_n == SHOW) begin
      an_n  = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_n);
      seg_n = (lz_en && (idx_n != '0) && zero_above[idx_n]) ? 7'h7F : decode(digit);
      dp_n  = ~active_dp_n[idx_n];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BLANK;
      cnt          <= CW'(BLANK_CLKS - 1);
      idx          <= '0;
      active       <= '0;
      active_dp    <= '0;
      pend_digits  <= '0;
      pend_dp      <= '0;
      pend         <= 1'b0;
      bus.in_ready <= 1'b1;
      an           <= '1;
      seg          <= 7'h7F;
      dp           <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      active       <= active_n;
      active_dp    <= active_dp_n;
      pend_digits  <= pend_digits_n;
      pend_dp      <= pend_dp_n;
      pend         <= pend_n;
      bus.in_ready <= ~pend_n;
      an           <= an_n;
      seg          <= seg_n;
      dp           <= dp_n;
      frame_done   <= boundary;
    end
  end
endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed bench for seg_scan_drv with N_DIGITS=4, BLANK_CLKS=2.
module tb_seg_scan_drv;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       lz_en = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;
  int         vectors = 0;
  int         errors = 0;
  int         fd_count = 0;

  seg_scan_if #(.N_DIGITS(4)) bus ();

  seg_scan_drv #(.N_DIGITS(4), .BLANK_CLKS(2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .lz_en(lz_en), .bus(bus),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // Tick accepted in SHOW, then wait out the 2-clock blank so the next digit is shown.
  task automatic scan_next();
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    clk1();
    clk1();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_digits = '0;
    bus.in_dp     = '0;
    #1 rst = 1'b1;
    clk1();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_ready", bus.in_ready, 1'b1);
    rst = 1'b0;

    clk1();
    chk("blank1_an", an, 4'hF);
    clk1();
    chk("show0_an", an, 4'b1110);
    chk("show0_seg", seg, 7'h40);

    tick = 1'b1;
    clk1();
    tick = 1'b0;
    chk("gap_a_an", an, 4'hF);
    clk1();
    chk("gap_b_an", an, 4'hF);
    clk1();
    chk("show1_an", an, 4'b1101);

    // second tick lands in BLANK and must not advance idx
    tick = 1'b1;
    clk1();
    clk1();
    tick = 1'b0;
    clk1();
    chk("blank_tick_an", an, 4'b1011);

    bus.in_valid  = 1'b1;
    bus.in_digits = 16'h1234;
    bus.in_dp     = 4'b0100;
    clk1();
    bus.in_valid  = 1'b0;
    chk("load_ready", bus.in_ready, 1'b0);
    chk("old_seg2", seg, 7'h40);
    scan_next();
    chk("old_seg3", seg, 7'h40);
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    chk("bnd1_fd", frame_done, 1'b1);
    chk("bnd1_ready", bus.in_ready, 1'b1);
    clk1();
    chk("fd_one_cycle", frame_done, 1'b0);
    clk1();
    chk("new_seg0", seg, 7'h19);
    chk("new_dp0", dp, 1'b1);
    scan_next();
    chk("new_seg1", seg, 7'h30);
    scan_next();
    chk("new_seg2", seg, 7'h24);
    chk("new_dp2", dp, 1'b0);
    scan_next();
    chk("new_seg3", seg, 7'h79);

    lz_en         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_digits = 16'h0070;
    bus.in_dp     = 4'b0000;
    clk1();
    bus.in_digits = 16'h00C5;
    chk("a_ready", bus.in_ready, 1'b0);
    clk1();
    chk("b_stall", bus.in_ready, 1'b0);
    chk("b_stall_seg", seg, 7'h79);
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    chk("bnd2_fd", frame_done, 1'b1);
    chk("bnd2_ready", bus.in_ready, 1'b1);
    clk1();
    bus.in_valid = 1'b0;
    chk("b_taken", bus.in_ready, 1'b0);
    clk1();
    chk("lz_seg0", seg, 7'h40);
    scan_next();
    chk("lz_seg1", seg, 7'h78);
    scan_next();
    chk("lz_seg2", seg, 7'h7F);
    chk("lz_an2", an, 4'b1011);
    scan_next();
    chk("lz_seg3", seg, 7'h7F);
    chk("lz_an3", an, 4'b0111);
    chk("lz_dp3", dp, 1'b1);
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    chk("bnd3_ready", bus.in_ready, 1'b1);
    clk1();
    clk1();
    chk("b_seg0", seg, 7'h12);
    scan_next();
    chk("dash_seg1", seg, 7'h3F);

    bus.in_valid  = 1'b1;
    bus.in_digits = 16'h9999;
    clk1();
    bus.in_valid  = 1'b0;
    chk("pre_rst_ready", bus.in_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_an", an, 4'hF);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_ready", bus.in_ready, 1'b1);
    #2 rst = 1'b0;
    clk1();
    clk1();
    chk("post_rst_an", an, 4'b1110);
    chk("post_rst_seg", seg, 7'h40);

    chk("frame_count", fd_count, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
